arb_session_ctrl: RTL and testbench

- Consumer of the round-robin arbiter's one-hot grant vector.
- Latches the granted requester and routes that requester's valid/ready/data/last stream onto a single shared destination port for one session.
- Ends the session on last beat, beat cap, or stall timeout, then pulses session_is_finished back to the arbiter so it rotates.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/arb_stream_mux.sv | 36 +++
 rtl/arb_session_ctrl.sv | 157 +++++++++++++++
 tb/tb_arb_session_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter and its session controller.
// The one-hot helpers take a 32-bit vector so they serve any N_REQ up to 32.
package arb_pkg;

    localparam int N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

    // Index of the lowest set bit; only meaningful when is_onehot() holds.
    function automatic logic [4:0] onehot_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_stream_mux.sv
// N_REQ-to-1 stream multiplexer: selects valid/last/data of one requester
// and steers the shared ready back to that requester only.
module arb_stream_mux
    import arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = 32,
    parameter int OWN_W  = 2
) (
    input  logic [OWN_W-1:0]        sel,
    input  logic [N_REQ-1:0]        src_valid,
    input  logic [N_REQ-1:0]        src_last,
    input  logic [N_REQ*DATA_W-1:0] src_data,
    input  logic                    dst_ready,
    output logic [N_REQ-1:0]        src_ready,
    output logic                    mux_valid,
    output logic                    mux_last,
    output logic [DATA_W-1:0]       mux_data
);

    always_comb begin
        mux_valid = 1'b0;
        mux_last  = 1'b0;
        mux_data  = '0;
        src_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (OWN_W'(i) == sel) begin
                mux_valid    = src_valid[i];
                mux_last     = src_last[i];
                mux_data     = src_data[i*DATA_W +: DATA_W];
                src_ready[i] = dst_ready;
            end
        end
    end

endmodule

// File: rtl/arb_session_ctrl.sv
// Session controller: latches the arbiter's one-hot grant, routes that requester's
// stream to the shared destination, and reports session end back to the arbiter.
module arb_session_ctrl
    import arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        grant,
    input  logic [N_REQ-1:0]        src_valid,
    input  logic [N_REQ-1:0]        src_last,
    input  logic [N_REQ*DATA_W-1:0] src_data,
    output logic [N_REQ-1:0]        src_ready,
    output logic                    dst_valid,
    output logic                    dst_last,
    output logic [DATA_W-1:0]       dst_data,
    input  logic                    dst_ready,
    output logic                    session_is_finished,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    grant_err
);

    localparam int OWN_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [OWN_W-1:0]   own;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               abort;

    logic [31:0]        grant_ext;
    logic               grant_onehot;
    logic [4:0]         grant_idx;

    logic [N_REQ-1:0]   mux_ready;
    logic               mux_valid;
    logic               mux_last;
    logic [DATA_W-1:0]  mux_data;

    logic               active;
    logic               hs;
    logic               at_cap;
    logic               last_beat;
    logic               stall_expire;

    assign grant_ext    = 32'(grant);
    assign grant_onehot = is_onehot(grant_ext);
    assign grant_idx    = onehot_index(grant_ext);

    arb_stream_mux #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .OWN_W  (OWN_W)
    ) u_mux (
        .sel       (own),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_data  (src_data),
        .dst_ready (dst_ready),
        .src_ready (mux_ready),
        .mux_valid (mux_valid),
        .mux_last  (mux_last),
        .mux_data  (mux_data)
    );

    assign active       = (state == ST_ACTIVE);
    assign hs           = active & mux_valid & dst_ready;
    assign at_cap       = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign last_beat    = mux_last | at_cap;
    assign stall_expire = (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A handshake in the same cycle as stall expiry keeps the session alive.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_onehot) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (hs && last_beat)        state_nxt = ST_FINISH;
                else if (!hs && stall_expire) state_nxt = ST_FINISH;
            end
            ST_FINISH: state_nxt = ST_GAP;
            ST_GAP:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own       <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            abort     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_onehot) begin
                        own       <= OWN_W'(grant_idx);
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                        abort     <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (hs) begin
                        beat_cnt  <= beat_cnt + BEAT_W'(1);
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                        if (stall_expire) abort <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        src_ready           = '0;
        dst_valid           = 1'b0;
        dst_last            = 1'b0;
        dst_data            = '0;
        session_is_finished = 1'b0;
        timeout_err         = 1'b0;
        grant_err           = 1'b0;
        busy                = 1'b0;
        case (state)
            ST_IDLE: grant_err = (grant != '0) && !grant_onehot;
            ST_ACTIVE: begin
                busy      = 1'b1;
                src_ready = mux_ready;
                dst_valid = mux_valid;
                dst_last  = last_beat;
                dst_data  = mux_data;
            end
            ST_FINISH: begin
                busy                = 1'b1;
                session_is_finished = 1'b1;
                timeout_err         = abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arb_session_ctrl.sv
// Self-checking bench for arb_session_ctrl: per-scenario tasks plus a
// destination-side scoreboard fed by the source driver.
module tb_arb_session_ctrl;
    import arb_pkg::*;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;
    localparam int TIMEOUT   = 64;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        grant = '0;
    logic [N_REQ-1:0]        src_valid = '0;
    logic [N_REQ-1:0]        src_last = '0;
    logic [N_REQ*DATA_W-1:0] src_data = '0;
    logic [N_REQ-1:0]        src_ready;
    logic                    dst_valid;
    logic                    dst_last;
    logic [DATA_W-1:0]       dst_data;
    logic                    dst_ready = 1'b0;
    logic                    session_is_finished;
    logic                    busy;
    logic                    timeout_err;
    logic                    grant_err;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    logic [N_REQ-1:0] own_mask = '0;
    logic [DATA_W:0]  exp_q[$];

    arb_session_ctrl #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .grant(grant), .src_valid(src_valid), .src_last(src_last),
        .src_data(src_data), .src_ready(src_ready), .dst_valid(dst_valid), .dst_last(dst_last),
        .dst_data(dst_data), .dst_ready(dst_ready), .session_is_finished(session_is_finished),
        .busy(busy), .timeout_err(timeout_err), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Destination monitor: every accepted beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((src_ready & ~own_mask) != '0) begin
                bad++;
                $display("FAIL src_ready_owner: got %b, allowed mask %b", src_ready, own_mask);
            end
            if (dst_valid && dst_ready) begin
                logic [DATA_W:0] e;
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got last=%b data=%h, queue empty", dst_last, dst_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({dst_last, dst_data} !== e) begin
                        bad++;
                        $display("FAIL beat_data: got last=%b data=%h, expected last=%b data=%h",
                                 dst_last, dst_data, e[DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    // Source driver: presents n beats from requester own, holding each until accepted.
    task automatic drive_burst(input int own, input int n, input bit with_last, input bit toggle_rdy);
        int beat = 0;
        int cycles = 0;
        bit pushed = 0;
        bit rdy = 1;
        logic [DATA_W-1:0] d = '0;
        bit lst;
        while (beat < n) begin
            if (cycles >= 200) begin
                total++;
                bad++;
                $display("FAIL burst_budget: got %0d beats, expected %0d", beat, n);
                break;
            end
            cyc();
            cycles++;
            if (!pushed) begin
                d = $urandom;
                lst = (with_last && beat == n - 1) || (beat == MAX_BEATS - 1);
                exp_q.push_back({lst, d});
                pushed = 1;
            end
            src_valid[own] = 1'b1;
            src_last[own]  = with_last && (beat == n - 1);
            src_data[own*DATA_W +: DATA_W] = d;
            dst_ready = toggle_rdy ? rdy : 1'b1;
            rdy = ~rdy;
            @(negedge clk);
            if (dst_valid && dst_ready) begin
                beat++;
                pushed = 0;
            end
        end
        cyc();
        src_valid[own] = 1'b0;
        src_last[own]  = 1'b0;
        dst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        total++;
        if ({dst_valid, dst_last, dst_data, src_ready, session_is_finished, busy, timeout_err, grant_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h ready=%b sif=%b busy=%b te=%b ge=%b, expected all 0",
                     dst_valid, dst_last, dst_data, src_ready, session_is_finished, busy, timeout_err, grant_err);
        end
        total++;
        if (dut.state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d, expected %0d", dut.state, ST_IDLE);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_session();
        grant = 4'b0100;
        own_mask = 4'b0100;
        cyc();
        grant = 4'b0000;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_enter_active: got busy=%b, expected 1", busy);
        end
        drive_burst(2, 3, 1, 0);
        @(negedge clk);
        total++;
        if (session_is_finished !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_finish: got sif=%b te=%b busy=%b, expected 1 0 1", session_is_finished, timeout_err, busy);
        end
        cyc();
        @(negedge clk);
        total++;
        if (session_is_finished !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_gap: got sif=%b busy=%b, expected 0 0", session_is_finished, busy);
        end
        cyc();
        @(negedge clk);
        total++;
        if (dut.state !== ST_IDLE) begin
            bad++;
            $display("FAIL single_idle: got state=%0d, expected %0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_beat_cap();
        grant = 4'b0010;
        own_mask = 4'b0010;
        cyc();
        grant = 4'b0000;
        drive_burst(1, MAX_BEATS, 0, 0);
        @(negedge clk);
        total++;
        if (session_is_finished !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL cap_finish: got sif=%b te=%b, expected 1 0", session_is_finished, timeout_err);
        end
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        int act = 0;
        grant = 4'b0001;
        own_mask = 4'b0001;
        cyc();
        grant = 4'b0000;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && session_is_finished === 1'b0) act++;
            cyc();
        end
        total++;
        if (act !== TIMEOUT) begin
            bad++;
            $display("FAIL timeout_active_cycles: got %0d, expected %0d", act, TIMEOUT);
        end
        @(negedge clk);
        total++;
        if (session_is_finished !== 1'b1 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_abort: got sif=%b te=%b, expected 1 1", session_is_finished, timeout_err);
        end
        cyc();
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width: got te=%b, expected 0", timeout_err);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        grant = 4'b1000;
        own_mask = 4'b1000;
        cyc();
        grant = 4'b0000;
        hs_cnt = 0;
        drive_burst(3, 4, 1, 1);
        @(negedge clk);
        total++;
        if (hs_cnt !== 4) begin
            bad++;
            $display("FAIL bp_handshakes: got %0d, expected 4", hs_cnt);
        end
        total++;
        if (session_is_finished !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_finish: got sif=%b te=%b, expected 1 0", session_is_finished, timeout_err);
        end
        cyc();
        cyc();
    endtask

    task automatic test_bad_grant_and_reset();
        grant = 4'b0110;
        own_mask = 4'b0000;
        @(negedge clk);
        total++;
        if (grant_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_grant_pulse: got ge=%b busy=%b, expected 1 0", grant_err, busy);
        end
        cyc();
        grant = 4'b0000;
        @(negedge clk);
        total++;
        if (dut.state !== ST_IDLE || grant_err !== 1'b0) begin
            bad++;
            $display("FAIL bad_grant_stay: got state=%0d ge=%b, expected %0d 0", dut.state, grant_err, ST_IDLE);
        end
        grant = 4'b0001;
        own_mask = 4'b0001;
        cyc();
        grant = 4'b0000;
        src_valid[0] = 1'b1;
        src_data[DATA_W-1:0] = $urandom;
        @(negedge clk);
        total++;
        if (dst_valid !== 1'b1 || dst_data !== src_data[DATA_W-1:0]) begin
            bad++;
            $display("FAIL reset_pre_active: got valid=%b data=%h, expected 1 %h", dst_valid, dst_data, src_data[DATA_W-1:0]);
        end
        cyc();
        rst = 1'b1;
        cyc();
        dst_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({dst_valid, src_ready, session_is_finished, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got valid=%b ready=%b sif=%b busy=%b te=%b, expected all 0",
                     dst_valid, src_ready, session_is_finished, busy, timeout_err);
        end
        rst = 1'b0;
        dst_ready = 1'b0;
        src_valid = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            total++;
            if (session_is_finished !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_finish: got sif=%b busy=%b, expected 0 0", session_is_finished, busy);
            end
        end
    endtask

    task automatic test_grant_change();
        grant = 4'b0100;
        own_mask = 4'b0100;
        cyc();
        grant = 4'b1000;
        src_valid[3] = 1'b1;
        src_data[3*DATA_W +: DATA_W] = $urandom;
        drive_burst(2, 3, 1, 0);
        grant = 4'b0000;
        src_valid[3] = 1'b0;
        @(negedge clk);
        total++;
        if (session_is_finished !== 1'b1) begin
            bad++;
            $display("FAIL grant_change_finish: got sif=%b, expected 1", session_is_finished);
        end
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_session();
        test_beat_cap();
        test_timeout();
        test_backpressure();
        test_bad_grant_and_reset();
        test_grant_change();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d beats left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
